// File: rtl/branch_resolve.sv
//-----------------------------------------------------------------------------
// branch_resolve
//
// Sits between decode and execute, directly downstream of the branch
// predictor. Each predicted control-flow instruction (JAL or conditional
// branch) that leaves decode is recorded in an in-order queue. When execute
// resolves the oldest instruction, its actual outcome is compared with the
// stored prediction:
//   - on a mismatch a one-cycle flush is raised together with the PC that
//     fetch should have followed, and the queue is cleared (everything younger
//     is wrong-path);
//   - conditional branches are reported back to the predictor as a
//     bp_branch/bp_result training pair;
//   - resolved and mispredicted instructions are counted.
//
// Parameters
//   DEPTH : queue entries (power of two, >= 2)
//   CNT_W : width of the performance counters
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   pred_valid    : push - a predicted JAL/branch leaves decode this cycle
//   pred_is_cond  : 1 = conditional branch, 0 = JAL
//   pred_taken    : predictor's taken decision
//   pred_pc       : PC of the instruction
//   pred_target   : pc+imm computed by the predictor
//   ex_valid      : pop - execute resolves the oldest queued instruction
//   ex_taken      : actual outcome
//   flush         : one-cycle pulse, kill younger instructions and redirect
//   redirect_pc   : correct fetch PC, valid while flush=1 (held otherwise)
//   bp_branch     : predictor update strobe (conditional branches only)
//   bp_result     : actual outcome for the predictor
//   full, empty   : queue status (decode must stall while full)
//   overflow      : sticky, push while full without a simultaneous pop
//   underflow     : sticky, pop while empty
//   branch_cnt    : resolved instructions
//   mispred_cnt   : mispredicted instructions
//-----------------------------------------------------------------------------
module branch_resolve #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid,
    input  logic             pred_is_cond,
    input  logic             pred_taken,
    input  logic [31:0]      pred_pc,
    input  logic [31:0]      pred_target,
    input  logic             ex_valid,
    input  logic             ex_taken,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic             bp_branch,
    output logic             bp_result,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int             PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    // The queue only needs to remember what to do if the prediction turns out
    // wrong: the path fetch did not follow.
    typedef struct packed {
        logic        is_cond;
        logic        pred_taken;
        logic [31:0] fallback_pc;
    } entry_t;

    //-------------------------------------------------------------------------
    // State
    //-------------------------------------------------------------------------
    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [PTR_W:0]     r_count;
    logic               r_full;
    logic               r_empty;
    logic               r_overflow;
    logic               r_underflow;
    logic               r_flush;
    logic [31:0]        r_redirect_pc;
    logic               r_bp_branch;
    logic               r_bp_result;
    logic [CNT_W-1:0]   r_branch_cnt;
    logic [CNT_W-1:0]   r_mispred_cnt;

    //-------------------------------------------------------------------------
    // Combinational
    //-------------------------------------------------------------------------
    entry_t             w_push_entry;
    entry_t             w_head_entry;
    logic               w_do_pop;
    logic               w_do_push;
    logic               w_mispred;
    logic [PTR_W-1:0]   w_head_nxt;
    logic [PTR_W-1:0]   w_tail_nxt;
    logic [PTR_W:0]     w_count_nxt;

    // A taken prediction means fetch went to the target, so the fallback is
    // the sequential PC; a not-taken prediction falls back to the target.
    always_comb begin
        w_push_entry.is_cond     = pred_is_cond;
        w_push_entry.pred_taken  = pred_taken;
        w_push_entry.fallback_pc = pred_taken ? (pred_pc + 32'd4) : pred_target;
    end

    assign w_head_entry = r_mem[r_head];
    assign w_do_pop     = ex_valid && !r_empty;
    assign w_mispred    = w_do_pop && (w_head_entry.pred_taken != ex_taken);

    // A pop in the same cycle frees a slot, so a push into a full queue is
    // accepted then. A push alongside a mispredicting pop is wrong-path and
    // is discarded.
    assign w_do_push    = pred_valid && (!r_full || w_do_pop) && !w_mispred;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count;
        if (w_mispred) begin
            w_head_nxt  = '0;
            w_tail_nxt  = '0;
            w_count_nxt = '0;
        end else begin
            if (w_do_pop) begin
                w_head_nxt = r_head + PTR_W'(1);
            end
            if (w_do_push) begin
                w_tail_nxt = r_tail + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   w_count_nxt = r_count + (PTR_W + 1)'(1);
                2'b01:   w_count_nxt = r_count - (PTR_W + 1)'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    //-------------------------------------------------------------------------
    // Queue storage
    //-------------------------------------------------------------------------
    // NOTE: the entry array has no reset; an entry is only ever read after it
    // has been written, and leaving it out of reset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_tail] <= w_push_entry;
        end
    end

    //-------------------------------------------------------------------------
    // Pointers and status
    //-------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_COUNT);
            r_empty <= (w_count_nxt == '0);
            if (pred_valid && r_full && !w_do_pop) begin
                r_overflow <= 1'b1;
            end
            if (ex_valid && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    //-------------------------------------------------------------------------
    // Resolution outputs (one cycle after the pop) and counters
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
            r_bp_branch   <= 1'b0;
            r_bp_result   <= 1'b0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_flush     <= w_mispred;
            r_bp_branch <= w_do_pop && w_head_entry.is_cond;
            r_bp_result <= w_do_pop && ex_taken;
            // redirect_pc only carries meaning alongside flush, so it holds
            // between mispredicts instead of toggling on every pop.
            if (w_mispred) begin
                r_redirect_pc <= w_head_entry.fallback_pc;
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
            if (w_do_pop) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
        end
    end

    assign flush       = r_flush;
    assign redirect_pc = r_redirect_pc;
    assign bp_branch   = r_bp_branch;
    assign bp_result   = r_bp_result;
    assign full        = r_full;
    assign empty       = r_empty;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule
